// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - two-requester round-robin access controller for the 32x32 RegFile
// Optional macro RFARB_FIXED_PRIO_EN: A always wins ties, no last_grant state.
module regfile_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr1,
  input  logic [ADDR_W-1:0] a_addr2,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_rsp_valid,
  input  logic              a_rsp_ready,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr1,
  input  logic [ADDR_W-1:0] b_addr2,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_rsp_valid,
  input  logic              b_rsp_ready,
  output logic [DATA_W-1:0] rsp_data1,
  output logic [DATA_W-1:0] rsp_data2,
  output logic [ADDR_W-1:0] rf_read1,
  output logic [ADDR_W-1:0] rf_read2,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_write_en,
  input  logic [DATA_W-1:0] rf_data_out_1,
  input  logic [DATA_W-1:0] rf_data_out_2
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP} state_t;

  state_t              r_state;
  logic                r_owner;
  logic [ADDR_W-1:0]   r_addr1;
  logic [ADDR_W-1:0]   r_addr2;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_write_en;
  logic [DATA_W-1:0]   r_rsp_data1;
  logic [DATA_W-1:0]   r_rsp_data2;
  logic                r_a_rsp_valid;
  logic                r_b_rsp_valid;
`ifndef RFARB_FIXED_PRIO_EN
  logic                r_last_grant;
`endif

  logic w_idle;
  logic w_pick_a;
  logic w_grant_a;
  logic w_grant_b;
  logic w_owner_rsp_ready;

  // r_last_grant = 1 means B won last, so A wins the next tie.
  always_comb begin
    w_idle = (r_state == S_IDLE);
`ifdef RFARB_FIXED_PRIO_EN
    w_pick_a = a_valid;
`else
    w_pick_a = a_valid & (~b_valid | r_last_grant);
`endif
    w_grant_a = w_idle & w_pick_a;
    w_grant_b = w_idle & b_valid & ~w_pick_a;
    w_owner_rsp_ready = r_owner ? b_rsp_ready : a_rsp_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_owner       <= 1'b0;
      r_addr1       <= '0;
      r_addr2       <= '0;
      r_wdata       <= '0;
      r_write_en    <= 1'b0;
      r_rsp_data1   <= '0;
      r_rsp_data2   <= '0;
      r_a_rsp_valid <= 1'b0;
      r_b_rsp_valid <= 1'b0;
`ifndef RFARB_FIXED_PRIO_EN
      r_last_grant  <= 1'b1;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_a | w_grant_b) begin
            r_owner    <= w_grant_b;
            r_addr1    <= w_grant_b ? b_addr1 : a_addr1;
            r_addr2    <= w_grant_b ? b_addr2 : a_addr2;
            r_wdata    <= w_grant_b ? b_wdata : a_wdata;
            r_write_en <= w_grant_b ? b_we    : a_we;
`ifndef RFARB_FIXED_PRIO_EN
            r_last_grant <= w_grant_b;
`endif
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_write_en <= 1'b0;
          r_state    <= S_CAPTURE;
        end
        S_CAPTURE: begin
          // RegFile outputs now reflect the command issued in the previous cycle.
          r_rsp_data1   <= rf_data_out_1;
          r_rsp_data2   <= rf_data_out_2;
          r_a_rsp_valid <= ~r_owner;
          r_b_rsp_valid <= r_owner;
          r_state       <= S_RESP;
        end
        S_RESP: begin
          if (w_owner_rsp_ready) begin
            r_a_rsp_valid <= 1'b0;
            r_b_rsp_valid <= 1'b0;
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign a_ready       = w_grant_a;
  assign b_ready       = w_grant_b;
  assign a_rsp_valid   = r_a_rsp_valid;
  assign b_rsp_valid   = r_b_rsp_valid;
  assign rsp_data1     = r_rsp_data1;
  assign rsp_data2     = r_rsp_data2;
  assign rf_read1      = r_addr1;
  assign rf_read2      = r_addr2;
  assign rf_write_reg  = r_addr1;
  assign rf_write_data = r_wdata;
  assign rf_write_en   = r_write_en;

endmodule
